// File: rtl/ball_motion.sv
// ball_motion: Pong ball physics stage, advances the ball once per game tick.
// Ports: clk, reset_n (async active-low); tick (one-clk game tick); start (leaves IDLE);
//   paddle_l_y/paddle_r_y (paddle top y, used on tick cycles only);
//   ball_x/ball_y (ball top-left); active (SERVE or PLAY); hit, score_l, score_r (one-clk pulses).
// Optional feature: define SPEEDUP_EN to raise the speed by one every four paddle hits.
module ball_motion #(
   parameter int FIELD_W     = 640,
   parameter int FIELD_H     = 480,
   parameter int BALL_SIZE   = 8,
   parameter int PADDLE_H    = 64,
   parameter int PADDLE_W    = 8,
   parameter int PADDLE_XL   = 16,
   parameter int PADDLE_XR   = 616,
   parameter int SPEED       = 2,
   parameter int MAX_SPEED   = 6,
   parameter int SERVE_TICKS = 60
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       start,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       active,
   output logic       hit,
   output logic       score_l,
   output logic       score_r
);
   typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORED} state_e;
   localparam int CW = $clog2(SERVE_TICKS + 1);
   localparam int SW = $clog2((SPEED > MAX_SPEED ? SPEED : MAX_SPEED) + 1);
   localparam logic [9:0]  CX   = 10'((FIELD_W - BALL_SIZE) / 2);
   localparam logic [9:0]  CY   = 10'((FIELD_H - BALL_SIZE) / 2);
   localparam logic [10:0] XMAX = 11'(FIELD_W - BALL_SIZE);
   localparam logic [10:0] YMAX = 11'(FIELD_H - BALL_SIZE);
   localparam logic [10:0] CL   = 11'(PADDLE_XL + PADDLE_W);
   localparam logic [10:0] CR   = 11'(PADDLE_XR - BALL_SIZE);
   localparam logic [10:0] BS   = 11'(BALL_SIZE);
   localparam logic [10:0] PH   = 11'(PADDLE_H);

   state_e        state_q, state_d;
   logic [9:0]    x_q, x_d, y_q, y_d, x_nxt, y_nxt;
   logic          dx_q, dx_d, dy_q, dy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hit_q, hit_d, score_l_q, score_l_d, score_r_q, score_r_d;
   logic [SW-1:0] spd;
   logic [10:0]   bx, by, s, pl, pr;
   logic          y_wall, ov_l, ov_r, hit_l, hit_r, miss_l, miss_r;

   // 11-bit intermediates so that position + speed never wraps.
   assign bx = {1'b0, x_q};
   assign by = {1'b0, y_q};
   assign s  = 11'(spd);
   assign pl = {1'b0, paddle_l_y};
   assign pr = {1'b0, paddle_r_y};

   assign y_wall = dy_q ? (by + s > YMAX) : (by < s);
   assign y_nxt  = 10'(y_wall ? (dy_q ? YMAX : 11'd0) : (dy_q ? by + s : by - s));

   // Overlap uses the pre-update ball_y.
   assign ov_l   = (by + BS > pl) && (by < pl + PH);
   assign ov_r   = (by + BS > pr) && (by < pr + PH);
   assign hit_l  = !dx_q && bx >= CL && bx - s <= CL && ov_l;
   assign hit_r  = dx_q && bx <= CR && bx + s >= CR && ov_r;
   assign miss_l = !dx_q && !hit_l && bx < s;
   assign miss_r = dx_q && !hit_r && bx + s > XMAX;
   assign x_nxt  = 10'(hit_l ? CL : hit_r ? CR : dx_q ? bx + s : bx - s);

`ifdef SPEEDUP_EN
   logic [SW-1:0] spd_q, spd_d;
   logic [1:0]    rally_q, rally_d;
   assign spd = spd_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         spd_q   <= SW'(SPEED);
         rally_q <= '0;
      end else begin
         spd_q   <= spd_d;
         rally_q <= rally_d;
      end
   end
   // The hit that wraps the rally counter from 3 to 0 bumps the speed.
   always_comb begin
      rally_d = rally_q;
      spd_d   = spd_q;
      if (state_q == SCORED) begin
         rally_d = '0;
         spd_d   = SW'(SPEED);
      end else if (hit_d) begin
         rally_d = rally_q + 2'd1;
         if (rally_q == 2'd3) spd_d = (spd_q >= SW'(MAX_SPEED)) ? SW'(MAX_SPEED) : spd_q + 1'b1;
      end
   end
`else
   assign spd = SW'(SPEED);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         x_q       <= CX;
         y_q       <= CY;
         dx_q      <= 1'b1;
         dy_q      <= 1'b1;
         cnt_q     <= '0;
         hit_q     <= 1'b0;
         score_l_q <= 1'b0;
         score_r_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         cnt_q     <= cnt_d;
         hit_q     <= hit_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SERVE;
         SERVE:   if (tick && cnt_q == CW'(SERVE_TICKS - 1)) state_d = PLAY;
         PLAY:    if (tick && (miss_l || miss_r)) state_d = SCORED;
         SCORED:  state_d = SERVE;
         default: state_d = IDLE;
      endcase
   end

   // A miss discards the Y update and leaves the ball where it was for the SCORED cycle.
   always_comb begin
      x_d       = x_q;
      y_d       = y_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      cnt_d     = cnt_q;
      hit_d     = 1'b0;
      score_l_d = 1'b0;
      score_r_d = 1'b0;
      case (state_q)
         IDLE:  cnt_d = '0;
         SERVE: if (tick) cnt_d = cnt_q + 1'b1;
         PLAY: if (tick) begin
            score_l_d = miss_r;
            score_r_d = miss_l;
            if (!(miss_l || miss_r)) begin
               x_d   = x_nxt;
               y_d   = y_nxt;
               dx_d  = (dx_q || hit_l) && !hit_r;
               dy_d  = dy_q ^ y_wall;
               hit_d = hit_l || hit_r;
            end
         end
         SCORED: begin
            x_d   = CX;
            y_d   = CY;
            dy_d  = !dy_q;
            cnt_d = '0;
         end
         default: ;
      endcase
   end

   assign ball_x  = x_q;
   assign ball_y  = y_q;
   assign active  = state_q == SERVE || state_q == PLAY;
   assign hit     = hit_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;
endmodule
